// File: rtl/nios_fifo_loader_if.sv
// -----------------------------------------------------------------------------
// nios_fifo_loader_if
//   Bundles the two buses of the FIFO loader:
//   - NIOS II multicycle custom-instruction side:
//     start, n, dataa, datab (to loader); done, result (from loader).
//   - FIFO write side:
//     Full, Empty (to loader); Push, DataIn (from loader).
//   The loader connects through the slave modport. Whatever drives the
//   CPU and FIFO side (a wrapper, or a testbench) connects through master.
// -----------------------------------------------------------------------------
interface nios_fifo_loader_if #(
  parameter int DataWidth = 32
);
  // Custom-instruction handshake
  logic                 start;
  logic [1:0]           n;
  logic [DataWidth-1:0] dataa;
  logic [DataWidth-1:0] datab;
  logic                 done;
  logic [DataWidth-1:0] result;

  // FIFO write port and flags
  logic                 Full;
  logic                 Empty;
  logic                 Push;
  logic [DataWidth-1:0] DataIn;

  modport slave (
    input  start, n, dataa, datab, Full, Empty,
    output done, result, Push, DataIn
  );

  modport master (
    output start, n, dataa, datab, Full, Empty,
    input  done, result, Push, DataIn
  );
endinterface

// File: rtl/nios_fifo_loader.sv
// -----------------------------------------------------------------------------
// nios_fifo_loader
//   Converts NIOS II multicycle custom instructions into single-cycle push
//   strobes for the PE-group weight/input FIFO. It also provides a status
//   query, a running push counter, and a stall watchdog, so software never
//   hangs on a FIFO that stays full.
//
// Opcodes (n):
//   0 push dataa, 1 push dataa then datab, 2 status, 3 clear.
//
// Ports:
//   clk     in   rising-edge clock
//   aclr    in   synchronous active-high reset; takes priority over clk_en
//   clk_en  in   low: all state holds, and Push/done are driven 0
//   bus     slave modport of nios_fifo_loader_if. It carries
//           start/n/dataa/datab/done/result and Full/Empty/Push/DataIn.
//
// Result word:
//   push ops   [1:0] = words pushed by this op, [DataWidth-1] = timeout
//   status     [CountWidth-1:0] = push count, [16] = Empty, [17] = Full,
//              [18] = sticky timeout flag
//   clear      0. The push count and the timeout flag clear in the DONE cycle.
// -----------------------------------------------------------------------------
module nios_fifo_loader #(
  parameter int DataWidth  = 32,
  parameter int CountWidth = 16,
  parameter int StallLimit = 255
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   clk_en,
  nios_fifo_loader_if.slave      bus
);

  // Parameter sanity: the status word needs bits up to 18, and the stall
  // counter is 16 bits wide.
  if (DataWidth < 19) begin : g_bad_data_width
    $error("nios_fifo_loader: DataWidth must be >= 19");
  end
  if (StallLimit < 1 || StallLimit > 65535) begin : g_bad_stall_limit
    $error("nios_fifo_loader: StallLimit must be in 1..65535");
  end
  if (CountWidth < 1 || CountWidth > 16) begin : g_bad_count_width
    $error("nios_fifo_loader: CountWidth must be in 1..16");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PUSH_A = 2'd1,
    PUSH_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0]  OpPush1  = 2'd0;
  localparam logic [1:0]  OpPush2  = 2'd1;
  localparam logic [1:0]  OpStatus = 2'd2;
  localparam logic [1:0]  OpClear  = 2'd3;
  // The watchdog fires on the StallLimit-th stalled cycle, when the counter
  // already holds StallLimit-1.
  localparam logic [15:0] StallLast = 16'(StallLimit - 1);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DataWidth-1:0]  a_q, a_d;
  logic [DataWidth-1:0]  b_q, b_d;
  logic [1:0]            words_q, words_d;       // words pushed by the current op
  logic                  timeout_q, timeout_d;   // current op hit the watchdog
  logic [CountWidth-1:0] push_count_q, push_count_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic                  timeout_flag_q, timeout_flag_d;  // sticky until clear

  logic                  push_c;
  logic [DataWidth-1:0]  data_in_c;
  logic                  done_c;
  logic [DataWidth-1:0]  result_c;
  logic                  active;

  // Outputs are gated by aclr as well as clk_en. A reset mid-op must not let
  // a push strobe through in the same cycle as the reset.
  assign active = clk_en && !aclr;

  always_comb begin
    // NOTE: every signal gets a default first, so a path that does not assign
    // it cannot infer a latch.
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    words_d        = words_q;
    timeout_d      = timeout_q;
    push_count_d   = push_count_q;
    stall_cnt_d    = stall_cnt_q;
    timeout_flag_d = timeout_flag_q;
    push_c         = 1'b0;
    data_in_c      = '0;
    done_c         = 1'b0;
    result_c       = '0;

    if (active) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_d         = bus.dataa;
            b_d         = bus.datab;
            op_d        = bus.n;
            words_d     = 2'd0;
            timeout_d   = 1'b0;
            stall_cnt_d = '0;
            state_d     = bus.n[1] ? DONE : PUSH_A;
          end
        end

        PUSH_A, PUSH_B: begin
          if (!bus.Full) begin
            // Full comes from registered pointers, so gating Push on its
            // current value is enough to never overfill the FIFO.
            push_c       = 1'b1;
            data_in_c    = (state_q == PUSH_A) ? a_q : b_q;
            push_count_d = push_count_q + CountWidth'(1);
            words_d      = words_q + 2'd1;
            stall_cnt_d  = '0;
            state_d      = (state_q == PUSH_A && op_q == OpPush2) ? PUSH_B : DONE;
          end else if (stall_cnt_q == StallLast) begin
            timeout_d      = 1'b1;
            timeout_flag_d = 1'b1;
            stall_cnt_d    = '0;
            state_d        = DONE;
          end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end

        DONE: begin
          done_c  = 1'b1;
          state_d = IDLE;
          unique case (op_q)
            OpPush1, OpPush2: begin
              result_c[1:0]           = words_q;
              result_c[DataWidth-1]   = timeout_q;
            end
            OpStatus: begin
              result_c[CountWidth-1:0] = push_count_q;
              result_c[16]             = bus.Empty;
              result_c[17]             = bus.Full;
              result_c[18]             = timeout_flag_q;
            end
            OpClear: begin
              push_count_d   = '0;
              timeout_flag_d = 1'b0;
            end
            default: ;
          endcase
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q        <= IDLE;
      op_q           <= 2'd0;
      a_q            <= '0;
      b_q            <= '0;
      words_q        <= 2'd0;
      timeout_q      <= 1'b0;
      push_count_q   <= '0;
      stall_cnt_q    <= '0;
      timeout_flag_q <= 1'b0;
    end else if (clk_en) begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      words_q        <= words_d;
      timeout_q      <= timeout_d;
      push_count_q   <= push_count_d;
      stall_cnt_q    <= stall_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign bus.Push   = push_c;
  assign bus.DataIn = data_in_c;
  assign bus.done   = done_c;
  assign bus.result = result_c;

endmodule

// File: tb/tb_nios_fifo_loader.sv
// -----------------------------------------------------------------------------
// tb_nios_fifo_loader
//   Scoreboard bench for nios_fifo_loader with DataWidth=32, CountWidth=8 and
//   StallLimit=4. The narrow counter lets the wrap run in a few hundred
//   pushes. Stimulus pushes the expected {cycle, value} of each Push and of
//   each done into queues. A negedge monitor pops and compares whenever the
//   DUT strobes Push or done.
// -----------------------------------------------------------------------------
module tb_nios_fifo_loader;

  localparam int DW = 32;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic aclr;
  logic clk_en;
  int   cyc = 0;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   done_base = 0;

  exp_t push_q[$];
  exp_t done_q[$];
  exp_t mon_e;

  nios_fifo_loader_if #(.DataWidth(DW)) bus ();

  nios_fifo_loader #(
    .DataWidth (DW),
    .CountWidth(8),
    .StallLimit(4)
  ) dut (
    .clk   (clk),
    .aclr  (aclr),
    .clk_en(clk_en),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_push(input int c, input logic [31:0] v);
    push_q.push_back('{cyc: c, val: v});
  endfunction

  function automatic void exp_done(input int c, input logic [31:0] v);
    done_q.push_back('{cyc: c, val: v});
  endfunction

  // Monitor: compares every Push and done against the scoreboard queues.
  always @(negedge clk) begin
    if (aclr) begin
      check("reset_push",   64'(bus.Push),   64'd0);
      check("reset_done",   64'(bus.done),   64'd0);
      check("reset_datain", 64'(bus.DataIn), 64'd0);
      check("reset_result", 64'(bus.result), 64'd0);
    end else begin
      if (bus.Push) begin
        check("push_while_full", 64'(bus.Full), 64'd0);
        if (push_q.size() == 0) begin
          check("unexpected_push", 64'(bus.DataIn), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = push_q.pop_front();
          check("push_data",  64'(bus.DataIn), 64'(mon_e.val));
          check("push_cycle", 64'(cyc),        64'(mon_e.cyc));
        end
      end else begin
        check("datain_idle", 64'(bus.DataIn), 64'd0);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(bus.result), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = done_q.pop_front();
          check("done_result", 64'(bus.result), 64'(mon_e.val));
          check("done_cycle",  64'(cyc),        64'(mon_e.cyc));
        end
      end else begin
        check("result_idle", 64'(bus.result), 64'd0);
      end
    end
  end

  // Drives start for one cycle (cycle t). Returns early in cycle t+1.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int t);
    @(posedge clk); #1;
    t         = cyc;
    done_base = done_cnt;
    bus.start = 1'b1;
    bus.n     = op;
    bus.dataa = a;
    bus.datab = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Waits until the monitor has seen a done, with a bounded number of cycles.
  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != done_base) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic status(input logic [31:0] expv);
    int t;
    start_op(2'd2, 32'h0, 32'h0, t);
    exp_done(t + 1, expv);
    wait_done(20);
  endtask

  initial begin
    int t;
    aclr      = 1'b1;
    clk_en    = 1'b1;
    bus.start = 1'b0;
    bus.n     = 2'd0;
    bus.dataa = '0;
    bus.datab = '0;
    bus.Full  = 1'b0;
    bus.Empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 aclr = 1'b0;
    repeat (2) @(posedge clk);

    // Single push, then status
    start_op(2'd0, 32'hA5A5_0001, 32'h0, t);
    exp_push(t + 1, 32'hA5A5_0001);
    exp_done(t + 2, 32'h1);
    wait_done(20);
    status(32'h0000_0001);
    bus.Empty = 1'b1;
    status(32'h0001_0001);
    bus.Empty = 1'b0;

    // Two-word push, no stall
    start_op(2'd1, 32'h11, 32'h22, t);
    exp_push(t + 1, 32'h11);
    exp_push(t + 2, 32'h22);
    exp_done(t + 3, 32'h2);
    wait_done(20);

    // Two-word push with Full held from T through T+3
    bus.Full = 1'b1;
    start_op(2'd1, 32'h11, 32'h22, t);
    exp_push(t + 4, 32'h11);
    exp_push(t + 5, 32'h22);
    exp_done(t + 6, 32'h2);
    repeat (3) @(posedge clk);
    #1 bus.Full = 1'b0;
    wait_done(20);

    // Watchdog on A: Full never releases, done at T+5 with the timeout bit
    bus.Full = 1'b1;
    start_op(2'd0, 32'hDEAD_BEEF, 32'h0, t);
    exp_done(t + 5, 32'h8000_0000);
    wait_done(20);
    status(32'h0006_0005);          // count 5, Full, TimeoutFlag
    bus.Full = 1'b0;

    // Clear, then status reads back zero
    start_op(2'd3, 32'h0, 32'h0, t);
    exp_done(t + 1, 32'h0);
    wait_done(20);
    status(32'h0000_0000);

    // clk_en low during T+1..T+2 freezes the op for two cycles
    start_op(2'd1, 32'h33, 32'h44, t);
    clk_en = 1'b0;
    exp_push(t + 3, 32'h33);
    exp_push(t + 4, 32'h44);
    exp_done(t + 5, 32'h2);
    repeat (2) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_done(20);

    // start held high through done: no second op may start
    @(posedge clk); #1;
    t         = cyc;
    done_base = done_cnt;
    bus.start = 1'b1;
    bus.n     = 2'd0;
    bus.dataa = 32'h55;
    exp_push(t + 1, 32'h55);
    exp_done(t + 2, 32'h1);
    wait_done(20);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);

    // Watchdog on B after A went out: result = 1 word + timeout
    start_op(2'd1, 32'h66, 32'h77, t);
    exp_push(t + 1, 32'h66);
    exp_done(t + 6, 32'h8000_0001);
    @(posedge clk); #1 bus.Full = 1'b1;
    wait_done(20);
    bus.Full = 1'b0;
    status(32'h0004_0004);          // count 4, TimeoutFlag

    // Reset in T+1 of a two-word op: no push, no done, state cleared
    start_op(2'd1, 32'h88, 32'h99, t);
    aclr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 aclr = 1'b0;
    repeat (2) @(posedge clk);
    status(32'h0000_0000);

    // Counter wrap with CountWidth=8: 255 pushes, then one more wraps to 0
    for (int i = 0; i < 127; i++) begin
      start_op(2'd1, 32'(2 * i), 32'(2 * i + 1), t);
      exp_push(t + 1, 32'(2 * i));
      exp_push(t + 2, 32'(2 * i + 1));
      exp_done(t + 3, 32'h2);
      wait_done(20);
    end
    start_op(2'd0, 32'd254, 32'h0, t);
    exp_push(t + 1, 32'd254);
    exp_done(t + 2, 32'h1);
    wait_done(20);
    status(32'h0000_00FF);
    start_op(2'd0, 32'd255, 32'h0, t);
    exp_push(t + 1, 32'd255);
    exp_done(t + 2, 32'h1);
    wait_done(20);
    status(32'h0000_0000);

    repeat (3) @(posedge clk);
    check("push_queue_drained", 64'(push_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/nios_fifo_loader.md
# nios_fifo_loader

Upstream feeder for the dual-read weight/input FIFO in the PE group. Accepts NIOS II multicycle custom instructions (start/done handshake) and converts each into one or two single-cycle push strobes into the FIFO, back-pressured by the FIFO's Full flag. It also provides a status query, a running push counter, and a stall watchdog so software never hangs on a full FIFO.

## Interface
Parameters:
- DataWidth, 32: width of dataa/datab/result/DataIn; must be ≥ 19.
- CountWidth, 16: width of the running push counter.
- StallLimit, 255: consecutive stalled cycles before a push op aborts; 1..65535.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- aclr  in  1  reset, **synchronous, active-high**; takes priority over clk_en.
- clk_en  in  1  when low, all state holds, and Push and done are driven 0.
- start  in  1  custom-instruction start; sampled only in IDLE.
- n  in  2  opcode: 0 = push dataa, 1 = push dataa then datab, 2 = status, 3 = clear.
- dataa  in  DataWidth  first word.
- datab  in  DataWidth  second word (n=1 only).
- done  out  1  one-cycle completion pulse.
- result  out  DataWidth  valid only while done=1, otherwise 0.
- Full  in  1  FIFO full flag.
- Empty  in  1  FIFO empty flag (primary read stream).
- Push  out  1  FIFO push strobe.
- DataIn  out  DataWidth  FIFO write data; 0 when Push=0.

## Operation
- States: IDLE, PUSH_A, PUSH_B, DONE.
- IDLE: on start=1, latch dataa, datab, n; n=0/1 → PUSH_A; n=2/3 → DONE. start is ignored in every other state.
- PUSH_A: if Full=0, assert Push with DataIn=A, increment PushCount, clear StallCnt; then go to PUSH_B for n=1, DONE for n=0. If Full=1, assert no Push and increment StallCnt.
- PUSH_B: same as PUSH_A with B; then DONE.
- Watchdog: in PUSH_A or PUSH_B, if Full=1 and StallCnt reaches StallLimit−1 (i.e. the StallLimit-th stalled cycle), abort to DONE with the timeout bit set, and set the sticky TimeoutFlag. StallCnt clears on any push and on entry to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Result formats (unused bits 0):
  - push ops: [1:0] = words pushed by this op (0/1/2); [DataWidth−1] = timeout.
  - status (n=2): [CountWidth−1:0] = PushCount; [16] = Empty; [17] = Full; [18] = TimeoutFlag. Empty and Full are sampled in the DONE cycle.
  - clear (n=3): result = 0; PushCount and TimeoutFlag are cleared in the DONE cycle.
- PushCount wraps modulo 2^CountWidth.
- The loader never asserts Push while Full=1. Full is a registered-pointer flag, so sampling it in the same cycle as Push is sufficient.

## Timing
- Reset values: state IDLE; Push=0, DataIn=0, done=0, result=0, PushCount=0, StallCnt=0, TimeoutFlag=0.
- Reset mid-op: abandon the op at the next edge. No done is ever produced for it, and no further Push occurs.
- Latency with start at cycle T and no stall (clk_en=1 throughout):
  - n=0: Push at T+1, done at T+2.
  - n=1: Push at T+1 and T+2, done at T+3.
  - n=2/3: done at T+1.
- Each cycle of Full=1 adds one cycle. Worst-case timeout on A: done at T+StallLimit+1.
- clk_en low freezes the state machine mid-op. Cycle counts above are in clk_en-high cycles.
- The earliest new start is accepted in the cycle after done (IDLE). A start coinciding with done is ignored.

## Test plan
- Reset, then start n=0, dataa=0xA5A5_0001 → Push=1 with DataIn=0xA5A5_0001 at T+1; done at T+2 with result=0x1; then status returns PushCount=1, Empty=0.
- n=1 with dataa=0x11, datab=0x22 and Full=0 → Push at T+1 (0x11) and T+2 (0x22); done at T+3 with result=0x2.
- n=1 with Full=1 during T+1..T+3, released at T+4 → Push 0x11 at T+4, 0x22 at T+5; done at T+6; result=0x2, timeout bit=0.
- StallLimit=4, n=0, Full held at 1 → no Push ever; done at T+5 with result=0x8000_0000; status shows bit18=1. Then n=3 → status returns 0.
- 65536 single pushes with CountWidth=16 → PushCount wraps to 0.
- aclr=1 asserted at T+1 of an n=1 op → no Push at T+2, no done; all outputs 0; the next n=2 reports PushCount=0.
